// File: rtl/gpr_writeback_unit.sv
// GPR write-port producer: in-order result FIFO that drains one write per cycle into the
// register file, plus a per-register busy scoreboard for read-after-write hazard queries.
module gpr_writeback_unit #(
    parameter int unsigned num_regs    = 32,
    parameter int unsigned l2_num_regs = 5,
    parameter int unsigned depth       = 4,
    parameter int unsigned l2_depth    = 2,
    parameter int unsigned word_size   = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_reserve,
    input  logic [l2_num_regs-1:0] i_reserve_sel,
    input  logic                   i_result_valid,
    input  logic [l2_num_regs-1:0] i_result_sel,
    input  logic [word_size-1:0]   i_result_data,
    output logic                   o_result_ready,
    output logic                   o_load_gpr,
    output logic [l2_num_regs-1:0] o_load_gpr_sel,
    output logic [word_size-1:0]   o_load_gpr_data,
    input  logic [l2_num_regs-1:0] i_query_A_sel,
    output logic                   o_query_A_busy,
    input  logic [l2_num_regs-1:0] i_query_B_sel,
    output logic                   o_query_B_busy,
    output logic [l2_depth:0]      o_fifo_count
);

    localparam logic [l2_depth:0] DepthCnt = (l2_depth + 1)'(depth);

    logic [l2_depth-1:0]    wr_ptr_q, wr_ptr_d;
    logic [l2_depth-1:0]    rd_ptr_q, rd_ptr_d;
    logic [l2_depth:0]      count_q, count_d;
    logic [num_regs-1:0]    busy_q, busy_d;
    logic                   load_q, load_d;
    logic [l2_num_regs-1:0] sel_q, sel_d;
    logic [word_size-1:0]   data_q, data_d;

    logic [l2_num_regs-1:0] sel_mem  [depth];
    logic [word_size-1:0]   data_mem [depth];

    logic push;
    logic pop;

    assign o_result_ready = (count_q != DepthCnt);

    // Results for r0 complete the handshake but are dropped here.
    assign push = i_result_valid && o_result_ready && (i_result_sel != '0) && !i_flush;
    assign pop  = (count_q != '0) && !i_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + l2_depth'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + l2_depth'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (l2_depth + 1)'(1);
                2'b01:   count_d = count_q - (l2_depth + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Clear-on-pop is applied before set-on-reserve so a same-edge reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[sel_mem[rd_ptr_q]] = 1'b0;
        end
        if (i_reserve && (i_reserve_sel != '0)) begin
            busy_d[i_reserve_sel] = 1'b1;
        end
        if (i_flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        load_d = pop;
        sel_d  = sel_q;
        data_d = data_q;
        if (pop) begin
            sel_d  = sel_mem[rd_ptr_q];
            data_d = data_mem[rd_ptr_q];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            load_q   <= 1'b0;
            sel_q    <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            load_q   <= load_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge i_clk) begin
        if (push) begin
            sel_mem[wr_ptr_q]  <= i_result_sel;
            data_mem[wr_ptr_q] <= i_result_data;
        end
    end

    assign o_load_gpr      = load_q;
    assign o_load_gpr_sel  = sel_q;
    assign o_load_gpr_data = data_q;
    assign o_fifo_count    = count_q;
    assign o_query_A_busy  = (i_query_A_sel != '0) && busy_q[i_query_A_sel];
    assign o_query_B_busy  = (i_query_B_sel != '0) && busy_q[i_query_B_sel];

endmodule

// File: tb/tb_gpr_writeback_unit.sv
// Directed and random stimulus for gpr_writeback_unit, checked against a queue-based model.
module tb_gpr_writeback_unit;

    localparam int NumRegs = 32;
    localparam int L2Regs  = 5;
    localparam int Depth   = 4;
    localparam int L2Depth = 2;
    localparam int W       = 32;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              reserve;
    logic [L2Regs-1:0] reserve_sel;
    logic              res_valid;
    logic [L2Regs-1:0] res_sel;
    logic [W-1:0]      res_data;
    logic              res_ready;
    logic              load_gpr;
    logic [L2Regs-1:0] load_sel;
    logic [W-1:0]      load_data;
    logic [L2Regs-1:0] qa_sel;
    logic              qa_busy;
    logic [L2Regs-1:0] qb_sel;
    logic              qb_busy;
    logic [L2Depth:0]  fifo_count;

    gpr_writeback_unit #(
        .num_regs   (NumRegs),
        .l2_num_regs(L2Regs),
        .depth      (Depth),
        .l2_depth   (L2Depth),
        .word_size  (W)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_flush        (flush),
        .i_reserve      (reserve),
        .i_reserve_sel  (reserve_sel),
        .i_result_valid (res_valid),
        .i_result_sel   (res_sel),
        .i_result_data  (res_data),
        .o_result_ready (res_ready),
        .o_load_gpr     (load_gpr),
        .o_load_gpr_sel (load_sel),
        .o_load_gpr_data(load_data),
        .i_query_A_sel  (qa_sel),
        .o_query_A_busy (qa_busy),
        .i_query_B_sel  (qb_sel),
        .o_query_B_busy (qb_busy),
        .o_fifo_count   (fifo_count)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        logic [L2Regs-1:0] sel;
        logic [W-1:0]      data;
    } ent_t;

    ent_t              mq[$];
    bit                mbusy[NumRegs];
    logic              exp_load;
    logic [L2Regs-1:0] exp_sel;
    logic [W-1:0]      exp_data;

    int total;
    int bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_busy(input logic [L2Regs-1:0] s);
        return (s != 0) && mbusy[s];
    endfunction

    task automatic model_reset();
        mq.delete();
        foreach (mbusy[r]) mbusy[r] = 1'b0;
        exp_load = 1'b0;
        exp_sel  = '0;
        exp_data = '0;
    endtask

    // One clock edge of the architectural behaviour, using the inputs currently driven.
    task automatic model_edge();
        bit   ready_pre;
        ent_t e;
        ready_pre = (mq.size() != Depth);
        if (flush) begin
            mq.delete();
            foreach (mbusy[r]) mbusy[r] = 1'b0;
            exp_load = 1'b0;
        end else begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                exp_load = 1'b1;
                exp_sel  = e.sel;
                exp_data = e.data;
                mbusy[e.sel] = 1'b0;
            end else begin
                exp_load = 1'b0;
            end
            if (reserve && reserve_sel != 0) mbusy[reserve_sel] = 1'b1;
            if (res_valid && ready_pre && res_sel != 0) begin
                e.sel  = res_sel;
                e.data = res_data;
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_outputs();
        check("ready", 64'(res_ready), 64'(mq.size() != Depth));
        check("count", 64'(fifo_count), 64'(mq.size()));
        check("load", 64'(load_gpr), 64'(exp_load));
        check("load_sel", 64'(load_sel), 64'(exp_sel));
        check("load_data", 64'(load_data), 64'(exp_data));
        check("busy_a", 64'(qa_busy), 64'(model_busy(qa_sel)));
        check("busy_b", 64'(qb_busy), 64'(model_busy(qb_sel)));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic sweep_busy();
        for (int r = 0; r < NumRegs; r++) begin
            qa_sel = L2Regs'(r);
            qb_sel = L2Regs'(NumRegs - 1 - r);
            #1;
            check("sweep_a", 64'(qa_busy), 64'(model_busy(qa_sel)));
            check("sweep_b", 64'(qb_busy), 64'(model_busy(qb_sel)));
        end
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        reserve   = 1'b0;
        res_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();
        reserve_sel = '0;
        res_sel     = '0;
        res_data    = '0;
        qa_sel      = 5'd5;
        qb_sel      = 5'd0;
        model_reset();
        #120;
        rst_n = 1'b1;
        #5;
        check_outputs();
        check("idle_ready", 64'(res_ready), 64'd1);
        check("idle_busy5", 64'(qa_busy), 64'd0);

        // Reserve r5, then its result; busy until the write pops.
        reserve = 1'b1; reserve_sel = 5'd5;
        step();
        check("r5_reserved", 64'(qa_busy), 64'd1);
        reserve = 1'b0; res_valid = 1'b1; res_sel = 5'd5; res_data = 32'hDEADBEEF;
        step();
        check("r5_still_busy", 64'(qa_busy), 64'd1);
        res_valid = 1'b0;
        step();
        check("r5_load", 64'(load_gpr), 64'd1);
        check("r5_data", 64'(load_data), 64'hDEADBEEF);
        check("r5_free", 64'(qa_busy), 64'd0);
        step();
        check("r5_done", 64'(load_gpr), 64'd0);

        // Back-to-back results for depth+1 cycles.
        for (int i = 0; i < Depth + 1; i++) begin
            res_valid = 1'b1; res_sel = L2Regs'(i + 1); res_data = 32'hA000_0000 + W'(i);
            step();
        end
        res_valid = 1'b0;
        step();
        step();

        // Result for r0 is swallowed.
        res_valid = 1'b1; res_sel = '0; res_data = 32'h12345678;
        step();
        res_valid = 1'b0;
        step();
        check("r0_no_load", 64'(load_gpr), 64'd0);
        check("r0_count", 64'(fifo_count), 64'd0);

        // Reserve r3 on the edge that pops r3's write.
        qa_sel = 5'd3; qb_sel = 5'd0;
        reserve = 1'b1; reserve_sel = 5'd3;
        step();
        reserve = 1'b0; res_valid = 1'b1; res_sel = 5'd3; res_data = 32'h0000_0333;
        step();
        res_valid = 1'b0; reserve = 1'b1; reserve_sel = 5'd3;
        step();
        reserve = 1'b0;
        check("r3_reserve_wins", 64'(qa_busy), 64'd1);
        check("q0_zero", 64'(qb_busy), 64'd0);

        // Reserve r4/r6/r7 with pending results, then flush (with a competing push).
        reserve = 1'b1; reserve_sel = 5'd4;
        step();
        reserve_sel = 5'd6; res_valid = 1'b1; res_sel = 5'd4; res_data = 32'h44;
        step();
        reserve_sel = 5'd7; res_sel = 5'd6; res_data = 32'h66;
        step();
        reserve = 1'b0; res_sel = 5'd7; res_data = 32'h77; flush = 1'b1;
        step();
        flush = 1'b0; res_valid = 1'b0;
        check("flush_count", 64'(fifo_count), 64'd0);
        check("flush_load", 64'(load_gpr), 64'd0);
        sweep_busy();

        // Asynchronous reset while a write is on the outputs.
        reserve = 1'b1; reserve_sel = 5'd9;
        res_valid = 1'b1; res_sel = 5'd9; res_data = 32'hCAFE0009;
        step();
        reserve = 1'b0; res_sel = 5'd10; res_data = 32'hCAFE000A;
        step();
        check("pre_rst_load", 64'(load_gpr), 64'd1);
        res_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_load", 64'(load_gpr), 64'd0);
        check("rst_sel", 64'(load_sel), 64'd0);
        check("rst_data", 64'(load_data), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        #2;
        rst_n = 1'b1;
        step();
        sweep_busy();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            flush       = ($urandom_range(0, 19) == 0);
            reserve     = $urandom_range(0, 1);
            reserve_sel = L2Regs'($urandom_range(0, 7));
            res_valid   = ($urandom_range(0, 3) != 0);
            res_sel     = L2Regs'($urandom_range(0, 7));
            res_data    = $urandom;
            qa_sel      = L2Regs'($urandom_range(0, 7));
            qb_sel      = L2Regs'($urandom_range(0, NumRegs - 1));
            step();
        end
        idle_inputs();
        step();
        step();
        sweep_busy();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
